// File: rtl/grayscale_stream.sv
// grayscale_stream: frame-aware RGB to grayscale converter with valid/ready
// handshakes on both sides, a two-stage arithmetic pipeline, per-frame
// channel-select modes and a one-cycle frame-complete pulse.
module grayscale_stream #(
  parameter int          PIX_W        = 8,
  parameter int          FRAME_PIXELS = 16384,
  parameter int unsigned WR           = 77,
  parameter int unsigned WG           = 150,
  parameter int unsigned WB           = 29,
  parameter int          CNT_W        = $clog2(FRAME_PIXELS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic               in_valid,
  input  logic [3*PIX_W-1:0] in_data,
  output logic               in_ready,
  output logic               pause,
  output logic               out_valid,
  output logic [PIX_W-1:0]   out_data,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   pix_count,
  output logic               busy,
  output logic               done
);

  localparam int COEF_W = 8;
  localparam int PROD_W = PIX_W + COEF_W;
  localparam int SUM_W  = PIX_W + 10;
  localparam int Y_W    = SUM_W - 8;

  localparam logic [COEF_W-1:0] WR_C = COEF_W'(WR);
  localparam logic [COEF_W-1:0] WG_C = COEF_W'(WG);
  localparam logic [COEF_W-1:0] WB_C = COEF_W'(WB);

  localparam logic [PIX_W-1:0] PIX_MAX    = '1;
  localparam logic [CNT_W-1:0] FRAME_N    = CNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Sum the weighted channels with a half-LSB bias, then drop the 1/256 scale.
  function automatic logic [Y_W-1:0] round_luma(input logic [PROD_W-1:0] pr,
                                                input logic [PROD_W-1:0] pg,
                                                input logic [PROD_W-1:0] pb);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(pr) + SUM_W'(pg) + SUM_W'(pb) + SUM_W'(128);
    return sum[SUM_W-1:8];
  endfunction

  // Clamp a widened luma value to the output pixel range.
  function automatic logic [PIX_W-1:0] sat_pix(input logic [Y_W-1:0] y);
    if (y > {2'b00, PIX_MAX}) begin
      return PIX_MAX;
    end
    return y[PIX_W-1:0];
  endfunction

  state_t             state;
  logic [1:0]         mode_r;
  logic [CNT_W-1:0]   in_cnt;
  logic [CNT_W-1:0]   pix_count_nxt;
  logic               stall;
  logic               accept;
  logic               out_hs;

  logic [PIX_W-1:0]   r_in;
  logic [PIX_W-1:0]   g_in;
  logic [PIX_W-1:0]   b_in;
  logic [PIX_W-1:0]   sel_in;

  logic               vld_p1;
  logic [PROD_W-1:0]  pr_p1;
  logic [PROD_W-1:0]  pg_p1;
  logic [PROD_W-1:0]  pb_p1;
  logic [PIX_W-1:0]   sel_p1;
  logic [1:0]         mode_p1;

  logic               vld_p2;
  logic [PIX_W-1:0]   data_p2;

  assign r_in = in_data[3*PIX_W-1 -: PIX_W];
  assign g_in = in_data[2*PIX_W-1 -: PIX_W];
  assign b_in = in_data[PIX_W-1:0];

  assign stall    = vld_p2 & ~out_ready;
  assign in_ready = (state == RUN) & ~stall;
  assign pause    = ~in_ready;
  assign accept   = in_valid & in_ready;
  assign out_hs   = vld_p2 & out_ready;

  assign out_valid = vld_p2;
  assign out_data  = data_p2;

  assign pix_count_nxt = pix_count + CNT_W'(out_hs);

  // Pick the pass-through channel for the frame's latched mode.
  always_comb begin
    sel_in = b_in;
    case (mode_r)
      2'd1:    sel_in = r_in;
      2'd2:    sel_in = g_in;
      default: sel_in = b_in;
    endcase
  end

  // Frame sequencing: input/output counting, busy and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode_r    <= 2'd0;
      in_cnt    <= '0;
      pix_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done      <= 1'b0;
      pix_count <= pix_count_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            mode_r    <= mode;
            in_cnt    <= '0;
            pix_count <= '0;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            in_cnt <= in_cnt + CNT_W'(1);
            if (in_cnt == FRAME_LAST) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // The last handshake itself closes the frame, so done follows it
          // on the very next edge.
          if (pix_count_nxt == FRAME_N) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Valid bits for both stages; they move together and freeze on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (!stall) begin
      vld_p1 <= accept;
      vld_p2 <= vld_p1;
    end
  end

  // ---- Stage 1: weighted channel products and pass-through channel ----
  always_ff @(posedge clk) begin
    if (!stall) begin
      pr_p1   <= PROD_W'(r_in) * PROD_W'(WR_C);
      pg_p1   <= PROD_W'(g_in) * PROD_W'(WG_C);
      pb_p1   <= PROD_W'(b_in) * PROD_W'(WB_C);
      sel_p1  <= sel_in;
      mode_p1 <= mode_r;
    end
  end

  // ---- Stage 2: rounded, saturated luma or selected channel ----
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p2 <= '0;
    end else if (!stall && vld_p1) begin
      data_p2 <= (mode_p1 == 2'd0) ? sat_pix(round_luma(pr_p1, pg_p1, pb_p1))
                                   : sel_p1;
    end
  end

endmodule

// File: tb/tb_grayscale_stream.sv
// Bench for grayscale_stream: two instances (default weights and all-255
// weights) share stimulus; a queue-based reference model predicts every
// output pixel from the luma formula and the frame's mode.
module tb_grayscale_stream;

  localparam int PW = 8;
  localparam int FP = 4;
  localparam int CW = $clog2(FP + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic          in_valid;
  logic [3*PW-1:0] in_data;
  logic          out_ready;

  logic          a_in_ready, a_pause, a_out_valid, a_busy, a_done;
  logic [PW-1:0] a_out_data;
  logic [CW-1:0] a_pix_count;
  logic          s_in_ready, s_pause, s_out_valid, s_busy, s_done;
  logic [PW-1:0] s_out_data;
  logic [CW-1:0] s_pix_count;

  always #5 clk = ~clk;

  grayscale_stream #(.PIX_W(PW), .FRAME_PIXELS(FP)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready), .pause(a_pause),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(out_ready),
    .pix_count(a_pix_count), .busy(a_busy), .done(a_done)
  );

  grayscale_stream #(.PIX_W(PW), .FRAME_PIXELS(FP), .WR(255), .WG(255), .WB(255)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready), .pause(s_pause),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(out_ready),
    .pix_count(s_pix_count), .busy(s_busy), .done(s_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: luma = round((R*wr + G*wg + B*wb) / 256), clamped to 255;
  // modes 1..3 return R, G or B unchanged.
  function automatic int model(input int px, input int m, input int wr, input int wg, input int wb);
    int r, g, b, y;
    r = (px >> 16) & 255;
    g = (px >> 8) & 255;
    b = px & 255;
    case (m)
      1: return r;
      2: return g;
      3: return b;
      default: begin
        y = (r * wr + g * wg + b * wb + 128) / 256;
        return (y > 255) ? 255 : y;
      end
    endcase
  endfunction

  typedef struct {
    int a;
    int s;
    int c;
  } exp_t;

  exp_t q[$];
  int   dir_a[$];
  int   dir_s[$];
  int   cyc = 0;
  int   acc_n = 0;
  int   last_acc = 0;
  int   done_cnt = 0;
  bit   done_seen = 0;
  bit   free_run = 0;
  bit   prev_stall = 0;
  logic [PW-1:0] prev_data = '0;
  int   frame_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples on the falling edge, scores accepts and handshakes.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      dir_a.delete();
      dir_s.delete();
      prev_stall = 0;
      acc_n = 0;
    end else begin
      if (prev_stall) begin
        chk("bp_hold_data", int'(a_out_data), int'(prev_data));
        chk("bp_hold_vld", int'(a_out_valid), 1);
      end
      if (a_out_valid && !out_ready) begin
        chk("bp_pause", int'(a_pause), 1);
        chk("bp_in_ready", int'(a_in_ready), 0);
      end
      if (in_valid && acc_n >= FP) chk("extra_in", int'(a_in_ready), 0);
      if (acc_n > 0 && acc_n < FP) chk("busy_mid", int'(a_busy), 1);
      if (in_valid && a_in_ready) begin
        e.a = model(int'(in_data), frame_mode, 77, 150, 29);
        e.s = model(int'(in_data), frame_mode, 255, 255, 255);
        e.c = cyc;
        q.push_back(e);
        acc_n++;
        if (acc_n == FP) last_acc = cyc;
      end
      if (a_out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("y_luma", int'(a_out_data), e.a);
          chk("y_sat", int'(s_out_data), e.s);
          chk("vld_sat", int'(s_out_valid), 1);
          if (free_run) chk("latency", cyc - e.c, 2);
        end
        if (dir_a.size() > 0) chk("y_dir", int'(a_out_data), dir_a.pop_front());
        if (dir_s.size() > 0) chk("y_dir_sat", int'(s_out_data), dir_s.pop_front());
      end
      if (a_done) begin
        done_cnt++;
        done_seen = 1;
        chk("done_sat", int'(s_done), 1);
        if (free_run) chk("done_lat", cyc - last_acc, 3);
      end
      prev_stall = a_out_valid && !out_ready;
      prev_data  = a_out_data;
    end
  end

  // kind: 0 random, 1 luma table, 2 mode pass-through, 3 white, 4 backpressure
  task automatic run_frame(input int kind, input logic [1:0] m);
    int px_tab[4];
    int v;
    px_tab = '{32'hC8C8C8, 32'hFF0000, 32'h00FF00, 32'h0000FF};
    @(posedge clk); #1;
    acc_n = 0;
    done_cnt = 0;
    done_seen = 0;
    free_run = (kind >= 1 && kind <= 3);
    frame_mode = int'(m);
    case (kind)
      1: begin
        dir_a = '{200, 77, 149, 29};
        dir_s = '{255, 254, 254, 254};
      end
      2: begin
        v = (m == 2'd1) ? 10 : (m == 2'd2) ? 20 : 30;
        dir_a = '{v, v, v, v};
        dir_s = '{v, v, v, v};
      end
      3: begin
        dir_a = '{255, 255, 255, 255};
        dir_s = '{255, 255, 255, 255};
      end
      default: ;
    endcase
    start = 1'b1;
    mode = m;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (done_seen) break;
      start = 1'b0;
      mode = 2'($urandom_range(0, 3));
      case (kind)
        1: begin
          in_valid = 1'b1; out_ready = 1'b1;
          in_data = (i < 4) ? 24'(px_tab[i]) : 24'($urandom);
        end
        2: begin in_valid = 1'b1; out_ready = 1'b1; in_data = 24'h0A141E; end
        3: begin in_valid = 1'b1; out_ready = 1'b1; in_data = 24'hFFFFFF; end
        4: begin
          in_valid = 1'b1;
          out_ready = !(i >= 2 && i < 7);
          in_data = 24'($urandom);
        end
        default: begin
          in_valid = ($urandom_range(0, 3) != 0);
          out_ready = ($urandom_range(0, 3) != 0);
          start = ($urandom_range(0, 7) == 0);
          in_data = 24'($urandom);
        end
      endcase
    end
    if (!done_seen) chk("done_timeout", 0, 1);
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("pix_count", int'(a_pix_count), FP);
    chk("pix_count_sat", int'(s_pix_count), FP);
    chk("busy_end", int'(a_busy), 0);
    chk("done_low", int'(a_done), 0);
    chk("done_once", done_cnt, 1);
    chk("accepts", acc_n, FP);
    chk("leftover", q.size(), 0);
  endtask

  task automatic reset_mid_frame(input logic [1:0] m);
    @(posedge clk); #1;
    acc_n = 0;
    done_cnt = 0;
    done_seen = 0;
    free_run = 0;
    frame_mode = int'(m);
    start = 1'b1;
    mode = m;
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      start = 1'b0;
      in_data = 24'($urandom);
    end
    @(posedge clk); #1;
    chk("pix_pre_rst", int'(a_pix_count), 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_pix", int'(a_pix_count), 0);
    chk("rst_vld", int'(a_out_valid), 0);
    chk("rst_data", int'(a_out_data), 0);
    chk("rst_in_ready", int'(a_in_ready), 0);
    chk("rst_pause", int'(a_pause), 1);
    chk("rst_done", int'(a_done), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mode = 2'd0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      start = 1'($urandom_range(0, 1));
      mode = 2'($urandom_range(0, 3));
      in_valid = 1'($urandom_range(0, 1));
      in_data = 24'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("reset_vld", int'(a_out_valid), 0);
      chk("reset_data", int'(a_out_data), 0);
      chk("reset_pix", int'(a_pix_count), 0);
      chk("reset_busy", int'(a_busy), 0);
      chk("reset_done", int'(a_done), 0);
      chk("reset_in_ready", int'(a_in_ready), 0);
      chk("reset_pause", int'(a_pause), 1);
      chk("reset_pause_sat", int'(s_pause), 1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;

    run_frame(1, 2'd0);
    run_frame(3, 2'd0);
    run_frame(2, 2'd1);
    run_frame(2, 2'd2);
    run_frame(2, 2'd3);
    run_frame(4, 2'd0);
    for (int k = 0; k < 25; k++) run_frame(0, 2'($urandom_range(0, 3)));
    reset_mid_frame(2'd0);
    run_frame(0, 2'd0);
    run_frame(4, 2'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grayscale_stream.md
# grayscale_stream

Parametrised, frame-aware RGB-to-grayscale converter for the video stitcher datapath. It sits between the camera-side frame memory (read port) and the grayscale frame memory (write port), and replaces the fixed 8-bit grayscaler. It adds configurable channel width and luma weights, per-frame channel-select modes, full valid/ready backpressure on both sides, a 2-stage arithmetic pipeline and a frame-complete pulse for the controller.

## Interface
Parameters:
- `PIX_W`, 8: bits per colour channel and per output pixel.
- `FRAME_PIXELS`, 16384: pixels per frame. Must be ≥ 1.
- `WR`, 77: red weight, unsigned 8-bit, in units of 1/256.
- `WG`, 150: green weight, unsigned 8-bit, in units of 1/256.
- `WB`, 29: blue weight, unsigned 8-bit, in units of 1/256.
- `CNT_W`, `$clog2(FRAME_PIXELS+1)`: width of the pixel counter.

Ports:
- `clk`  in  1  single clock. All logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a frame. Only honoured in IDLE.
- `mode`  in  2  sampled on an accepted `start`. 0 = weighted luma, 1 = R only, 2 = G only, 3 = B only.
- `in_valid`  in  1  input pixel is valid.
- `in_data`  in  3*PIX_W  packed pixel, {R,G,B}, with R in the MSBs.
- `in_ready`  out  1  block can accept an input pixel.
- `pause`  out  1  equals `~in_ready`. Drives the upstream memory's pause input.
- `out_valid`  out  1  output pixel is valid.
- `out_data`  out  PIX_W  grayscale pixel.
- `out_ready`  in  1  downstream accepts the output pixel.
- `pix_count`  out  CNT_W  number of output pixels handed off in the current frame.
- `busy`  out  1  high while in RUN or DRAIN.
- `done`  out  1  one-cycle frame-complete pulse.

## Operation
- The state machine has four states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start`. In the same cycle, `mode_r` latches `mode`, and `pix_count` and the input counter clear.
  - RUN: an input is accepted when `in_valid & in_ready`. When the FRAME_PIXELS-th input is accepted, the state moves to DRAIN.
  - DRAIN: no further inputs are accepted. When the output counter reaches FRAME_PIXELS, the state moves to DONE.
  - DONE: `done` = 1 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored.
- `in_ready = (state==RUN) & ~stall`, where `stall = out_valid & ~out_ready`.
- The pipeline has two stages, S1 and S2. Both hold their contents while `stall` is high and advance together otherwise.
  - S1 registers the three products: R·WR, G·WG, B·WB, each PIX_W+8 bits wide.
  - S2 forms the result and registers it as `out_data`, with valid → `out_valid`.
- Luma arithmetic (mode 0):
  - sum = products + 128, computed in PIX_W+10 bits.
  - y = sum >> 8.
  - If y > 2^PIX_W − 1, the output saturates to 2^PIX_W − 1.
- Modes 1–3: pass the selected channel unchanged. The pipeline latency is the same as mode 0.
- An output handshake is `out_valid & out_ready`. Each handshake increments `pix_count`. `pix_count` holds its value after DONE until the next accepted `start`.
- The input counter never exceeds FRAME_PIXELS, so no extra inputs are accepted after the last one.

## Timing
- Reset values: state = IDLE, S1 and S2 valids = 0, `out_valid` = 0, `out_data` = 0, `pix_count` = 0, `busy` = 0, `done` = 0, `in_ready` = 0, `pause` = 1, `mode_r` = 0.
- Latency with `out_ready` held high: an input accepted at edge N appears with `out_valid` = 1 after edge N+2.
- Throughput is 1 pixel/clk when there is no backpressure.
- Backpressure: while `out_valid & ~out_ready`, `out_data` and `out_valid` are stable and `in_ready` = 0. No data is lost or duplicated.
- `done` rises on the edge after the clock in which the last output handshake happens.
- `start` may be accepted on the cycle after DONE, i.e. in IDLE.
- Reset mid-frame: on the next edge the block is in the reset state, and in-flight pixels are discarded.
- `rst` and `start` in the same cycle: reset wins.
- FRAME_PIXELS = 1: RUN → DRAIN on the first accept. `done` comes 3 cycles after the accept if `out_ready` = 1.

## Test plan
- Reset: hold `rst` 3 cycles, drive random inputs → all outputs equal their reset values, `pause` = 1.
- Luma values (PIX_W = 8, default weights, `out_ready` = 1):
  - {200,200,200} → 200
  - {255,0,0} → 77
  - {0,255,0} → 149
  - {0,0,255} → 29
  - Each appears 2 cycles after acceptance.
- Saturation: WR = WG = WB = 255, input {255,255,255} → 255.
- Modes: `mode` = 1/2/3 with input {10,20,30} → 10, 20, 30 respectively. Changing `mode` mid-frame has no effect.
- Frame flow, FRAME_PIXELS = 4, continuous valid/ready → exactly 4 outputs, `pix_count` = 4, a single `done` pulse 3 cycles after the 4th accept, and `in_ready` = 0 for any extra input.
- Backpressure: drop `out_ready` for 5 cycles mid-frame → `out_data` is stable, `pause` = 1, and the full output sequence matches the reference model in order with no gaps. Asserting `rst` mid-frame then returns the block to IDLE with `pix_count` = 0.
